// File: rtl/mmp_iddmm_pkg.sv
// Shared definitions for the mmp_iddmm engine arbiter and engine wrappers:
// arbiter FSM states and the engine write-enable bit positions.
package mmp_iddmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        START,
        RUN,
        DONE
    } arb_state_e;

    localparam int unsigned WR_X = 0;
    localparam int unsigned WR_Y = 1;
    localparam int unsigned WR_M = 2;
    localparam int unsigned WR_W = 3;

endpackage

// File: rtl/mmp_rr_arb.sv
// Combinational round-robin pick: the first asserted req bit at or after ptr,
// wrapping modulo NREQ. Returns a one-hot winner and an any-request flag.
module mmp_rr_arb #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmp_iddmm_arb.sv
// Round-robin sharing of one mmp_iddmm_sp Montgomery engine between NREQ requesters.
// Optional MMP_ARB_PERF_EN adds saturating per-requester job and busy-cycle counters.
module mmp_iddmm_arb
    import mmp_iddmm_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned K      = 128,
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    input  logic [NREQ*WR_W-1:0]     ld_ena,
    input  logic [NREQ*ADDR_W-1:0]   ld_addr,
    input  logic [NREQ*K-1:0]        ld_x,
    input  logic [NREQ*K-1:0]        ld_y,
    input  logic [NREQ*K-1:0]        ld_m,
    input  logic [NREQ*K-1:0]        ld_m1,
    input  logic [NREQ-1:0]          ld_done,
    output logic [WR_W-1:0]          eng_wr_ena,
    output logic [ADDR_W-1:0]        eng_wr_addr,
    output logic [K-1:0]             eng_wr_x,
    output logic [K-1:0]             eng_wr_y,
    output logic [K-1:0]             eng_wr_m,
    output logic [K-1:0]             eng_wr_m1,
    output logic                     eng_task_req,
    input  logic                     eng_task_grant,
    input  logic [K-1:0]             eng_task_res,
    input  logic                     eng_task_end,
    output logic [NREQ-1:0]          res_val,
    output logic [K-1:0]             res_data,
    output logic [NREQ-1:0]          res_end,
    output logic                     busy
`ifdef MMP_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]       perf_jobs,
    output logic [31:0]              perf_busy
`endif
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WR_W-1:0]  wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [K-1:0]     wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [K-1:0]     wr_m_q, wr_m_d, wr_m1_q, wr_m1_d;
    logic             task_req_q, task_req_d;

    logic [NREQ-1:0]  win;
    logic             win_any;
    logic [IDX_W-1:0] win_idx;

    logic [WR_W-1:0]  sel_ena;
    logic [ADDR_W-1:0] sel_addr;
    logic [K-1:0]     sel_x, sel_y, sel_m, sel_m1;
    logic             sel_req, sel_done;

    mmp_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = IDX_W'(i);
        end
    end

    // Operand port of the granted requester only; all others are never looked at.
    always_comb begin
        sel_ena  = '0;
        sel_addr = '0;
        sel_x    = '0;
        sel_y    = '0;
        sel_m    = '0;
        sel_m1   = '0;
        sel_req  = 1'b0;
        sel_done = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_q == IDX_W'(i)) begin
                sel_ena  = ld_ena[i*WR_W +: WR_W];
                sel_addr = ld_addr[i*ADDR_W +: ADDR_W];
                sel_x    = ld_x[i*K +: K];
                sel_y    = ld_y[i*K +: K];
                sel_m    = ld_m[i*K +: K];
                sel_m1   = ld_m1[i*K +: K];
                sel_req  = req[i];
                sel_done = ld_done[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        wr_ena_d   = '0;
        wr_addr_d  = wr_addr_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_m_d     = wr_m_q;
        wr_m1_d    = wr_m1_q;
        task_req_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) state_d = GRANT;
            end
            GRANT: begin
                if (win_any) begin
                    w_d     = win_idx;
                    gnt_d   = win;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (!sel_req) begin
                    state_d = DONE;
                end else begin
                    wr_ena_d = sel_ena;
                    if (|sel_ena) begin
                        wr_addr_d = sel_addr;
                        wr_x_d    = sel_x;
                        wr_y_d    = sel_y;
                        wr_m_d    = sel_m;
                        wr_m1_d   = sel_m1;
                    end
                    if (sel_done) state_d = START;
                end
            end
            // task_req is registered, so a write issued alongside ld_done lands one cycle ahead of it.
            START: begin
                task_req_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (eng_task_end) state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (w_q == IDX_W'(NREQ - 1)) ? '0 : w_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            wr_ena_q   <= '0;
            wr_addr_q  <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_m_q     <= '0;
            wr_m1_q    <= '0;
            task_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            wr_ena_q   <= wr_ena_d;
            wr_addr_q  <= wr_addr_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_m_q     <= wr_m_d;
            wr_m1_q    <= wr_m1_d;
            task_req_q <= task_req_d;
        end
    end

    always_comb begin
        res_val  = '0;
        res_end  = '0;
        res_data = '0;
        if (state_q == RUN) begin
            res_val[w_q] = eng_task_grant;
            res_end[w_q] = eng_task_end;
            res_data     = eng_task_res;
        end
    end

    assign gnt          = gnt_q;
    assign busy         = (state_q != IDLE);
    assign eng_wr_ena   = wr_ena_q;
    assign eng_wr_addr  = wr_addr_q;
    assign eng_wr_x     = wr_x_q;
    assign eng_wr_y     = wr_y_q;
    assign eng_wr_m     = wr_m_q;
    assign eng_wr_m1    = wr_m1_q;
    assign eng_task_req = task_req_q;

`ifdef MMP_ARB_PERF_EN
    logic [NREQ*16-1:0] perf_jobs_q, perf_jobs_d;
    logic [31:0]        perf_busy_q, perf_busy_d;

    always_comb begin
        perf_jobs_d = perf_jobs_q;
        perf_busy_d = perf_busy_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (res_end[i] && (perf_jobs_q[i*16 +: 16] != '1)) begin
                perf_jobs_d[i*16 +: 16] = perf_jobs_q[i*16 +: 16] + 16'd1;
            end
        end
        if (busy && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_jobs_q <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_jobs_q <= perf_jobs_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_jobs = perf_jobs_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// Scoreboard bench for mmp_iddmm_arb (NREQ=3) with a behavioural Montgomery engine model
// that streams N result words after each task_req.
module tb_mmp_iddmm_arb;

    localparam int unsigned NREQ = 3;
    localparam int unsigned K    = 128;
    localparam int unsigned N    = 32;
    localparam int unsigned AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req, gnt, ld_done, res_val, res_end;
    logic [NREQ*3-1:0]    ld_ena;
    logic [NREQ*AW-1:0]   ld_addr;
    logic [NREQ*K-1:0]    ld_x, ld_y, ld_m, ld_m1;
    logic [2:0]           eng_wr_ena;
    logic [AW-1:0]        eng_wr_addr;
    logic [K-1:0]         eng_wr_x, eng_wr_y, eng_wr_m, eng_wr_m1;
    logic                 eng_task_req, eng_task_grant, eng_task_end;
    logic [K-1:0]         eng_task_res, res_data;
    logic                 busy;

    mmp_iddmm_arb #(
        .NREQ   (NREQ),
        .K      (K),
        .N      (N),
        .ADDR_W (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .gnt            (gnt),
        .ld_ena         (ld_ena),
        .ld_addr        (ld_addr),
        .ld_x           (ld_x),
        .ld_y           (ld_y),
        .ld_m           (ld_m),
        .ld_m1          (ld_m1),
        .ld_done        (ld_done),
        .eng_wr_ena     (eng_wr_ena),
        .eng_wr_addr    (eng_wr_addr),
        .eng_wr_x       (eng_wr_x),
        .eng_wr_y       (eng_wr_y),
        .eng_wr_m       (eng_wr_m),
        .eng_wr_m1      (eng_wr_m1),
        .eng_task_req   (eng_task_req),
        .eng_task_grant (eng_task_grant),
        .eng_task_res   (eng_task_res),
        .eng_task_end   (eng_task_end),
        .res_val        (res_val),
        .res_data       (res_data),
        .res_end        (res_end),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // x*y*2^-(K*N) mod m on word 0 (small odd m), xor of the operands on other words.
    function automatic logic [K-1:0] res_word(input logic [K-1:0] x, input logic [K-1:0] y,
                                              input logic [K-1:0] m, input int idx);
        logic [63:0] r, mm;
        if (idx != 0 || m[0] == 1'b0) return x ^ y ^ m;
        mm = {32'b0, m[31:0]};
        r  = ({32'b0, x[31:0]} * {32'b0, y[31:0]}) % mm;
        for (int j = 0; j < int'(K * N); j++) r = r[0] ? (r + mm) >> 1 : r >> 1;
        return {64'b0, r};
    endfunction

    // Engine model: RAM capture and task_req counting.
    logic [K-1:0] ex [N];
    logic [K-1:0] ey [N];
    logic [K-1:0] em [N];
    int treq_cnt = 0;

    always @(posedge clk) begin
        if (eng_wr_ena[0]) ex[eng_wr_addr] <= eng_wr_x;
        if (eng_wr_ena[1]) ey[eng_wr_addr] <= eng_wr_y;
        if (eng_wr_ena[2]) em[eng_wr_addr] <= eng_wr_m;
        if (eng_task_req) treq_cnt <= treq_cnt + 1;
    end

    bit spur = 1'b0;

    initial begin
        eng_task_grant = 1'b0;
        eng_task_end   = 1'b0;
        eng_task_res   = '0;
        forever begin
            @(posedge clk);
            if (spur) begin
                #1 eng_task_grant = 1'b1; eng_task_end = 1'b1; eng_task_res = '1;
                @(posedge clk);
                #1 eng_task_grant = 1'b0; eng_task_end = 1'b0; eng_task_res = '0;
            end else if (eng_task_req && !rst) begin
                bit ab;
                ab = 1'b0;
                repeat (2) @(posedge clk);
                for (int i = 0; i < int'(N); i++) begin
                    #1;
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    eng_task_grant = 1'b1;
                    eng_task_res   = res_word(ex[i], ey[i], em[i], i);
                    @(posedge clk);
                end
                #1 eng_task_grant = 1'b0; eng_task_res = '0;
                if (!ab && !rst) begin
                    eng_task_end = 1'b1;
                    @(posedge clk);
                    #1 eng_task_end = 1'b0;
                end
            end
        end
    end

    // Scoreboard
    typedef struct {
        int           r;
        int           idx;
        logic [K-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    int           end_q[$];
    logic [K-1:0] cap_word0 = '0;
    logic [NREQ-1:0] gnt_prev = '0;
    int           gnt1_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_val != '0) begin
                if (exp_q.size() == 0) begin
                    check("res_val_unexpected", K'(res_val), '0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("res_val_sel", K'(res_val), K'(1) << e.r);
                    check("res_data", res_data, e.data);
                    if (e.idx == 0) cap_word0 = res_data;
                end
            end
            if (res_end != '0) begin
                if (end_q.size() == 0) begin
                    check("res_end_unexpected", K'(res_end), '0);
                end else begin
                    int r;
                    r = end_q.pop_front();
                    check("res_end_sel", K'(res_end), K'(1) << r);
                end
            end
            if (gnt != gnt_prev && gnt != '0) begin
                check("gnt_switch_while_held", K'(gnt_prev), '0);
                check("gnt_onehot", K'($onehot(gnt)), K'(1));
            end
            if (gnt[1]) gnt1_cnt = gnt1_cnt + 1;
            gnt_prev = gnt;
        end else begin
            gnt_prev = '0;
        end
    end

    task automatic serve(output int w, input bit fixed, input bit iso, input bit abort10);
        int t;
        int c0;
        int nb;
        logic [K-1:0] xs [N];
        logic [K-1:0] ys [N];
        logic [K-1:0] ms [N];
        w = -1;
        t = 0;
        @(negedge clk);
        while (gnt == '0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (gnt == '0) begin
            check("gnt_timeout", K'(0), K'(1));
            return;
        end
        for (int i = 0; i < int'(NREQ); i++) if (gnt[i]) w = i;
        if (iso) begin
            int o;
            o  = (w + 1) % NREQ;
            c0 = treq_cnt;
            @(posedge clk);
            #1 ld_ena[o*3 +: 3] = 3'b111; ld_addr[o*AW +: AW] = AW'(3);
            ld_x[o*K +: K] = '1; ld_done[o] = 1'b1;
            @(posedge clk);
            #1 ld_ena = '0; ld_done = '0; ld_x = '0;
            @(negedge clk);
            check("iso_wr_ena", K'(eng_wr_ena), '0);
            repeat (3) @(negedge clk);
            check("iso_task_req", K'(treq_cnt - c0), '0);
            check("iso_still_busy", K'(busy), K'(1));
        end
        for (int i = 0; i < int'(N); i++) begin
            if (fixed) begin
                xs[i] = (i == 0) ? K'(3) : '0;
                ys[i] = (i == 0) ? K'(5) : '0;
                ms[i] = (i == 0) ? K'(7) : '0;
            end else if (i == 0) begin
                xs[i] = K'($urandom_range(1, 60000));
                ys[i] = K'($urandom_range(1, 60000));
                ms[i] = K'({$urandom_range(1, 30000), 1'b1});
            end else begin
                xs[i] = {$urandom, $urandom, $urandom, $urandom};
                ys[i] = {$urandom, $urandom, $urandom, $urandom};
                ms[i] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        c0 = treq_cnt;
        for (int i = 0; i < int'(N); i++) begin
            @(posedge clk);
            #1 ld_ena[w*3 +: 3] = 3'b111;
            ld_addr[w*AW +: AW] = AW'(i);
            ld_x[w*K +: K]  = xs[i];
            ld_y[w*K +: K]  = ys[i];
            ld_m[w*K +: K]  = ms[i];
            ld_m1[w*K +: K] = ~ms[i];
            ld_done[w]      = (i == int'(N) - 1);
        end
        @(posedge clk);
        #1 ld_ena = '0; ld_done = '0;
        for (int i = 0; i < int'(N); i++) exp_q.push_back('{w, i, res_word(xs[i], ys[i], ms[i], i)});
        end_q.push_back(w);
        t = 0;
        if (abort10) begin
            nb = 0;
            while (nb < 10 && t < 300) begin
                @(negedge clk);
                if (res_val[w]) nb++;
                t++;
            end
            check("beat10_reached", K'(nb), K'(10));
            rst = 1'b1;
            #1;
            check("rst_gnt", K'(gnt), '0);
            check("rst_res_val", K'(res_val), '0);
            check("rst_res_end", K'(res_end), '0);
            check("rst_res_data", res_data, '0);
            check("rst_busy", K'(busy), '0);
            check("rst_task_req", K'(eng_task_req), '0);
            check("rst_wr_ena", K'(eng_wr_ena), '0);
            return;
        end
        while (!res_end[w] && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("res_end_seen", K'(res_end[w]), K'(1));
        check("task_req_once", K'(treq_cnt - c0), K'(1));
        t = 0;
        while (gnt != '0 && t < 10) begin
            @(negedge clk);
            t++;
        end
    endtask

    int w;
    int c0;
    int g1;

    initial begin
        rst = 1'b1; req = '0; ld_ena = '0; ld_addr = '0; ld_done = '0;
        ld_x = '0; ld_y = '0; ld_m = '0; ld_m1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", K'(gnt), '0);
        check("reset_busy", K'(busy), '0);
        check("reset_res_val", K'(res_val), '0);
        check("reset_res_end", K'(res_end), '0);
        check("reset_wr_ena", K'(eng_wr_ena), '0);
        check("reset_task_req", K'(eng_task_req), '0);
        check("reset_res_data", res_data, '0);
        check("reset_wr_x", eng_wr_x, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fairness from pointer 0: 0,1,0,1
        req = 3'b011;
        for (int j = 0; j < 4; j++) begin
            serve(w, 1'b0, 1'b0, 1'b0);
            check("fair_order", K'(w), K'(j % 2));
        end

        // Pointer now 2, only req[0]: wraps to 0, pointer becomes 1
        req = 3'b001;
        serve(w, 1'b0, 1'b0, 1'b0);
        check("wrap_winner", K'(w), K'(0));
        req = 3'b011;
        serve(w, 1'b0, 1'b0, 1'b0);
        check("wrap_next_ptr", K'(w), K'(1));

        // Single fixed job on requester 0
        req = 3'b001;
        g1  = gnt1_cnt;
        serve(w, 1'b1, 1'b0, 1'b0);
        check("single_winner", K'(w), K'(0));
        check("single_word0", cap_word0, K'(4));
        check("single_gnt1_never", K'(gnt1_cnt - g1), '0);

        // Cancel requester 1 in LOAD
        req = 3'b010;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!gnt[1] && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("cancel_granted", K'(gnt), K'(3'b010));
        end
        c0 = treq_cnt;
        @(posedge clk);
        #1 req = '0;
        repeat (6) @(negedge clk);
        check("cancel_gnt_clear", K'(gnt), '0);
        check("cancel_idle", K'(busy), '0);
        check("cancel_no_task_req", K'(treq_cnt - c0), '0);
        req = 3'b001;
        serve(w, 1'b0, 1'b0, 1'b0);
        check("after_cancel_winner", K'(w), K'(0));

        // Foreign load traffic while requester 0 is in LOAD
        serve(w, 1'b0, 1'b1, 1'b0);
        check("iso_winner", K'(w), K'(0));
        req = '0;
        repeat (4) @(posedge clk);

        // Engine strobes outside RUN are ignored
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        check("spur_res_val", K'(res_val), '0);
        check("spur_res_end", K'(res_end), '0);
        check("spur_busy", K'(busy), '0);
        repeat (3) @(posedge clk);

        // Reset at result beat 10, then a clean job
        req = 3'b010;
        serve(w, 1'b0, 1'b0, 1'b1);
        req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        end_q.delete();
        repeat (2) @(posedge clk);
        req = 3'b001;
        serve(w, 1'b0, 1'b0, 1'b0);
        check("post_reset_winner", K'(w), K'(0));
        req = '0;
        repeat (5) @(posedge clk);

        check("sb_beats_drained", K'(exp_q.size()), '0);
        check("sb_ends_drained", K'(end_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog sim_time_exceeded got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
